msu_port: RTL and testbench

MSU_PORT -- requirements
Module: msu_port

---
 rtl/msu_port.sv | 267 ++++++++++++++++++++++++++
 tb/tb_msu_port.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msu_port.sv
`timescale 1ns/1ps
// msu_port: CPU-mapped audio control port with optional data prefetch path.
// Define MSU_PORT_DATA_EN to build the prefetch FIFO, fetch FSM and data port.
module msu_port #(
  parameter logic [15:0] BASE_ADDR  = 16'h2000,
  parameter int          FIFO_DEPTH = 8,
  parameter int          ADDR_W     = 32,
  parameter logic [2:0]  REVISION   = 3'd2
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              ENABLE,
  input  logic              RD_N,
  input  logic              WR_N,
  input  logic [23:0]       ADDR,
  input  logic [7:0]        DIN,
  output logic [7:0]        DOUT,
  output logic [15:0]       track_out,
  output logic              track_req,
  input  logic              track_mounting,
  input  logic              track_missing_in,
  output logic              trig_play,
  output logic              trig_pause,
  output logic              repeat_out,
  output logic [7:0]        volume_out,
  input  logic              playing_in,
  output logic              fetch_req,
  output logic [ADDR_W-1:0] fetch_addr,
  input  logic              fetch_ack,
  input  logic [7:0]        fetch_data
);

  logic        rd_n_q, wr_n_q, mount_q, miss_in_q, play_in_q;
  logic [15:0] off_full;
  logic [2:0]  off;
  logic        hit, wr_stb, rd_stb, rd_rise;
  logic        mount_fall, miss_rise, play_fall;
  logic [7:0]  head, rdata, dout_d, dout_q;
  logic        dbusy, fifo_empty;
  logic        unused_addr;

  // Banks 00-3F and 80-BF both have ADDR[22]=0.
  assign off_full = ADDR[15:0] - BASE_ADDR;
  assign off      = off_full[2:0];
  assign hit      = ENABLE && !ADDR[22] && (off_full < 16'd8);
  assign wr_stb   = hit && wr_n_q && !WR_N;
  assign rd_stb   = hit && rd_n_q && !RD_N;
  assign rd_rise  = !rd_n_q && RD_N;
  assign unused_addr = ^{ADDR[23], ADDR[21:16]};

  assign mount_fall = mount_q && !track_mounting;
  assign miss_rise  = !miss_in_q && track_missing_in;
  assign play_fall  = play_in_q && !playing_in;

  logic [7:0]  track_lsb_q, track_lsb_d, volume_q, volume_d;
  logic [15:0] track_q, track_d;
  logic        repeat_q, repeat_d, playing_q, playing_d, missing_q, missing_d;
  logic        abusy_q, abusy_d;
  logic        track_req_q, track_req_d, trig_play_q, trig_play_d, trig_pause_q, trig_pause_d;

  always_comb begin
    track_lsb_d  = track_lsb_q;
    track_d      = track_q;
    volume_d     = volume_q;
    repeat_d     = repeat_q;
    playing_d    = playing_q;
    missing_d    = missing_q;
    abusy_d      = abusy_q;
    track_req_d  = 1'b0;
    trig_play_d  = 1'b0;
    trig_pause_d = 1'b0;
    if (mount_fall) begin
      abusy_d   = 1'b0;
      missing_d = track_missing_in;
    end
    if (miss_rise) begin
      missing_d = 1'b1;
      abusy_d   = 1'b0;
    end
    if (play_fall && playing_q && !repeat_q) playing_d = 1'b0;
    if (wr_stb) begin
      case (off)
        3'd4: track_lsb_d = DIN;
        3'd5: begin
          track_d     = {DIN, track_lsb_q};
          track_req_d = 1'b1;
          abusy_d     = 1'b1;
          missing_d   = 1'b0;
          playing_d   = 1'b0;
        end
        3'd6: volume_d = DIN;
        3'd7: if (!abusy_q) begin
          repeat_d = DIN[1];
          if (track_q != 16'd0 && !missing_q) begin
            playing_d    = DIN[0];
            trig_play_d  = DIN[0];
            trig_pause_d = !DIN[0];
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rdata = 8'h00;
    case (off)
      3'd0: rdata = {dbusy, abusy_q, repeat_q, playing_q, missing_q, REVISION};
      3'd1: rdata = fifo_empty ? 8'h00 : head;
      3'd2: rdata = 8'h53;
      3'd3: rdata = 8'h2D;
      3'd4: rdata = 8'h4D;
      3'd5: rdata = 8'h53;
      3'd6: rdata = 8'h55;
      3'd7: rdata = 8'h31;
      default: rdata = 8'h00;
    endcase
    dout_d = rd_stb ? rdata : dout_q;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd_n_q       <= 1'b1;
      wr_n_q       <= 1'b1;
      mount_q      <= 1'b1;
      miss_in_q    <= 1'b0;
      play_in_q    <= 1'b0;
      dout_q       <= 8'h00;
      track_lsb_q  <= 8'h00;
      track_q      <= 16'h0000;
      volume_q     <= 8'h00;
      repeat_q     <= 1'b0;
      playing_q    <= 1'b0;
      missing_q    <= 1'b0;
      abusy_q      <= 1'b0;
      track_req_q  <= 1'b0;
      trig_play_q  <= 1'b0;
      trig_pause_q <= 1'b0;
    end else begin
      rd_n_q       <= RD_N;
      wr_n_q       <= WR_N;
      mount_q      <= track_mounting;
      miss_in_q    <= track_missing_in;
      play_in_q    <= playing_in;
      dout_q       <= dout_d;
      track_lsb_q  <= track_lsb_d;
      track_q      <= track_d;
      volume_q     <= volume_d;
      repeat_q     <= repeat_d;
      playing_q    <= playing_d;
      missing_q    <= missing_d;
      abusy_q      <= abusy_d;
      track_req_q  <= track_req_d;
      trig_play_q  <= trig_play_d;
      trig_pause_q <= trig_pause_d;
    end
  end

  assign DOUT       = dout_q;
  assign track_out  = track_q;
  assign track_req  = track_req_q;
  assign trig_play  = trig_play_q;
  assign trig_pause = trig_pause_q;
  assign repeat_out = repeat_q;
  assign volume_out = volume_q;

`ifdef MSU_PORT_DATA_EN
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DISCARD} fsm_t;

  fsm_t              state_q, state_d;
  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [PW-1:0]     rptr_q, wptr_q;
  logic [PW:0]       cnt_q;
  logic [ADDR_W-1:0] next_addr_q, next_addr_d, req_addr_q, req_addr_d;
  logic [23:0]       seek_q;
  logic              dbusy_q, pop_pend_q;
  logic              seek, full, push, pop;

  assign seek       = wr_stb && (off == 3'd3);
  assign fifo_empty = (cnt_q == '0);
  assign full       = (cnt_q == (PW+1)'(FIFO_DEPTH));
  // A flush in the same cycle as an ack wins: the acked byte is dropped.
  assign push       = (state_q == S_REQ) && fetch_ack && !seek && !full;
  assign pop        = rd_rise && pop_pend_q && !fifo_empty;
  assign head       = mem_q[rptr_q];
  assign dbusy      = dbusy_q;
  assign fetch_req  = (state_q != S_IDLE);
  assign fetch_addr = req_addr_q;

  always_comb begin
    state_d     = state_q;
    next_addr_d = next_addr_q;
    req_addr_d  = req_addr_q;
    case (state_q)
      S_IDLE: if (!seek && !full) begin
        state_d    = S_REQ;
        req_addr_d = next_addr_q;
      end
      S_REQ: begin
        if (seek)           state_d = fetch_ack ? S_IDLE : S_DISCARD;
        else if (fetch_ack) state_d = S_IDLE;
      end
      S_DISCARD: if (fetch_ack) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (seek)      next_addr_d = ADDR_W'({DIN, seek_q});
    else if (push) next_addr_d = next_addr_q + ADDR_W'(1);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= S_IDLE;
      next_addr_q <= '0;
      req_addr_q  <= '0;
      seek_q      <= '0;
      dbusy_q     <= 1'b0;
      pop_pend_q  <= 1'b0;
      rptr_q      <= '0;
      wptr_q      <= '0;
      cnt_q       <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 8'h00;
    end else begin
      state_q     <= state_d;
      next_addr_q <= next_addr_d;
      req_addr_q  <= req_addr_d;
      if (wr_stb) begin
        case (off)
          3'd0: seek_q[7:0]   <= DIN;
          3'd1: seek_q[15:8]  <= DIN;
          3'd2: seek_q[23:16] <= DIN;
          default: ;
        endcase
      end
      if (seek) begin
        rptr_q     <= '0;
        wptr_q     <= '0;
        cnt_q      <= '0;
        pop_pend_q <= 1'b0;
        dbusy_q    <= 1'b1;
      end else begin
        if (push) begin
          mem_q[wptr_q] <= fetch_data;
          wptr_q        <= wptr_q + PW'(1);
        end
        if (pop) rptr_q <= rptr_q + PW'(1);
        if (push && !pop)      cnt_q <= cnt_q + (PW+1)'(1);
        else if (pop && !push) cnt_q <= cnt_q - (PW+1)'(1);
        // Busy until data lands, whether after a flush or an empty read.
        if (push)                                        dbusy_q <= 1'b0;
        else if (rd_stb && off == 3'd1 && fifo_empty)    dbusy_q <= 1'b1;
        if (rd_stb)       pop_pend_q <= (off == 3'd1) && !fifo_empty;
        else if (rd_rise) pop_pend_q <= 1'b0;
      end
    end
  end
`else
  logic unused_data;
  assign fifo_empty  = 1'b1;
  assign head        = 8'h00;
  assign dbusy       = 1'b0;
  assign fetch_req   = 1'b0;
  assign fetch_addr  = '0;
  assign unused_data = ^{fetch_ack, fetch_data, rd_rise};
`endif

endmodule

// File: tb/tb_msu_port.sv
`timescale 1ns/1ps
// Scoreboard bench for msu_port: bus tasks, an auto-acking fetch responder and per-feature tests.
module tb_msu_port;
  logic        CLK = 1'b0;
  logic        RST_N, ENABLE, RD_N, WR_N;
  logic [23:0] ADDR;
  logic [7:0]  DIN, DOUT;
  logic [15:0] track_out;
  logic        track_req, track_mounting, track_missing_in, trig_play, trig_pause, repeat_out;
  logic [7:0]  volume_out;
  logic        playing_in, fetch_req, fetch_ack;
  logic [31:0] fetch_addr;
  logic [7:0]  fetch_data;

  int checks = 0, errors = 0;
  int ack_delay = 1, dly;
  int n_play = 0, n_pause = 0, n_treq = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] log_q[$];

  msu_port dut (
    .CLK(CLK), .RST_N(RST_N), .ENABLE(ENABLE), .RD_N(RD_N), .WR_N(WR_N), .ADDR(ADDR),
    .DIN(DIN), .DOUT(DOUT), .track_out(track_out), .track_req(track_req),
    .track_mounting(track_mounting), .track_missing_in(track_missing_in),
    .trig_play(trig_play), .trig_pause(trig_pause), .repeat_out(repeat_out),
    .volume_out(volume_out), .playing_in(playing_in), .fetch_req(fetch_req),
    .fetch_addr(fetch_addr), .fetch_ack(fetch_ack), .fetch_data(fetch_data)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (trig_play === 1'b1)  n_play++;
    if (trig_pause === 1'b1) n_pause++;
    if (track_req === 1'b1)  n_treq++;
  end

  // Host data responder: logs each request address, acks with data = addr[7:0].
  initial begin
    fetch_ack = 1'b0;
    fetch_data = 8'h00;
    forever begin
      @(negedge CLK);
      if (fetch_ack) fetch_ack = 1'b0;
      else if (fetch_req === 1'b1) begin
        log_q.push_back(fetch_addr);
        dly = ack_delay;
        repeat (dly - 1) @(negedge CLK);
        fetch_data = fetch_addr[7:0];
        fetch_ack = 1'b1;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [23:0] ra(input int o);
    return 24'h002000 + 24'(o);
  endfunction

  task automatic bus_write(input logic [23:0] a, input logic [7:0] d);
    @(negedge CLK); ADDR = a; DIN = d; ENABLE = 1'b1;
    @(negedge CLK); WR_N = 1'b0;
    @(negedge CLK);
    @(negedge CLK); WR_N = 1'b1;
    @(negedge CLK); ENABLE = 1'b0;
  endtask

  task automatic bus_read(input logic [23:0] a, output logic [7:0] d);
    @(negedge CLK); ADDR = a; ENABLE = 1'b1;
    @(negedge CLK); RD_N = 1'b0;
    @(negedge CLK); d = DOUT;
    @(negedge CLK); RD_N = 1'b1;
    @(negedge CLK); ENABLE = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    RST_N = 1'b0; ENABLE = 1'b0; RD_N = 1'b1; WR_N = 1'b1; ADDR = '0; DIN = '0;
    track_mounting = 1'b0; track_missing_in = 1'b0; playing_in = 1'b0;
    repeat (3) @(negedge CLK);
    checks++;
    if ({DOUT, track_out, track_req, trig_play, trig_pause, repeat_out, volume_out, fetch_req, fetch_addr} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got dout=%h track=%h vol=%h freq=%b faddr=%h want all zero",
               DOUT, track_out, volume_out, fetch_req, fetch_addr);
    end
    RST_N = 1'b1;
    exp_q.push_back(8'h02);
    bus_read(ra(0), d);
    checks++;
    if (d !== exp_q[0]) begin errors++; $display("FAIL reset_status: got %h want %h", d, exp_q[0]); end
    void'(exp_q.pop_front());
  endtask

  task automatic test_id();
    logic [7:0] d, e;
    logic [7:0] id [6] = '{8'h53, 8'h2D, 8'h4D, 8'h53, 8'h55, 8'h31};
    for (int o = 2; o < 8; o++) exp_q.push_back(id[o-2]);
    for (int o = 2; o < 8; o++) begin
      bus_read(24'h800000 | ra(o), d);
      e = exp_q.pop_front();
      checks++;
      if (d !== e) begin errors++; $display("FAIL id_bank80 off%0d: got %h want %h", o, d, e); end
    end
    for (int o = 2; o < 8; o++) begin
      bus_read(24'h400000 | ra(o), d);
      checks++;
      if (d !== 8'h31) begin errors++; $display("FAIL id_bank40_hold off%0d: got %h want 31", o, d); end
    end
  endtask

  task automatic test_audio_play();
    logic [7:0] d, e;
    int p0, q0, t0;
    p0 = n_play; q0 = n_pause; t0 = n_treq;
    track_mounting = 1'b1;
    bus_write(ra(4), 8'h03);
    bus_write(ra(5), 8'h00);
    checks++;
    if (track_out !== 16'h0003) begin errors++; $display("FAIL track_out: got %h want 0003", track_out); end
    checks++;
    if (n_treq - t0 !== 1) begin errors++; $display("FAIL track_req_pulses: got %0d want 1", n_treq - t0); end
    bus_write(ra(7), 8'h01);
    checks++;
    if (n_play - p0 !== 0) begin errors++; $display("FAIL play_while_busy: got %0d pulses want 0", n_play - p0); end
    track_mounting = 1'b0; track_missing_in = 1'b0;
    repeat (2) @(negedge CLK);
    bus_write(ra(7), 8'h03);
    checks++;
    if (n_play - p0 !== 1 || n_pause - q0 !== 0) begin
      errors++; $display("FAIL play_pulse: got play=%0d pause=%0d want 1/0", n_play - p0, n_pause - q0);
    end
    checks++;
    if (repeat_out !== 1'b1) begin errors++; $display("FAIL repeat_out: got %b want 1", repeat_out); end
    playing_in = 1'b1; repeat (2) @(negedge CLK);
    playing_in = 1'b0; repeat (2) @(negedge CLK);
    exp_q.push_back(8'h32);
    bus_read(ra(0), d); e = exp_q.pop_front();
    checks++;
    if (d !== e) begin errors++; $display("FAIL status_playing_repeat: got %h want %h", d, e); end
    bus_write(ra(7), 8'h01);
    playing_in = 1'b1; repeat (2) @(negedge CLK);
    playing_in = 1'b0; repeat (2) @(negedge CLK);
    exp_q.push_back(8'h02);
    bus_read(ra(0), d); e = exp_q.pop_front();
    checks++;
    if (d !== e || n_play - p0 !== 2) begin
      errors++; $display("FAIL track_end: got status %h plays %0d want %h plays 2", d, n_play - p0, e);
    end
    bus_write(ra(7), 8'h00);
    checks++;
    if (n_pause - q0 !== 1) begin errors++; $display("FAIL pause_pulse: got %0d want 1", n_pause - q0); end
    bus_write(ra(6), 8'h7F);
    bus_write(24'h400000 | ra(6), 8'h11);
    checks++;
    if (volume_out !== 8'h7F) begin errors++; $display("FAIL volume: got %h want 7f", volume_out); end
  endtask

  task automatic test_missing();
    logic [7:0] d, e;
    int p0;
    p0 = n_play;
    bus_write(ra(4), 8'h05);
    bus_write(ra(5), 8'h00);
    track_missing_in = 1'b1;
    repeat (2) @(negedge CLK);
    exp_q.push_back(8'h0A);
    exp_q.push_back(8'h0A);
    bus_read(ra(0), d); e = exp_q.pop_front();
    checks++;
    if (d !== e) begin errors++; $display("FAIL status_missing: got %h want %h", d, e); end
    bus_write(ra(7), 8'h01);
    bus_read(ra(0), d); e = exp_q.pop_front();
    checks++;
    if (d !== e || n_play !== p0) begin
      errors++; $display("FAIL play_missing: got status %h plays %0d want %h plays 0", d, n_play - p0, e);
    end
    track_missing_in = 1'b0;
  endtask

`ifdef MSU_PORT_DATA_EN
  task automatic seek_to(input logic [31:0] s);
    bus_write(ra(0), s[7:0]);
    bus_write(ra(1), s[15:8]);
    bus_write(ra(2), s[23:16]);
    log_q.delete();
    bus_write(ra(3), s[31:24]);
  endtask

  task automatic test_seek();
    logic [7:0] d, e;
    ack_delay = 1;
    seek_to(32'h0000_1000);
    repeat (40) @(negedge CLK);
    bus_read(ra(0), d);
    checks++;
    if (d[7] !== 1'b0) begin errors++; $display("FAIL seek_busy_clear: got status %h want bit7=0", d); end
    for (int i = 0; i < 5; i++) exp_q.push_back(8'(i));
    for (int i = 0; i < 5; i++) begin
      bus_read(ra(1), d); e = exp_q.pop_front();
      checks++;
      if (d !== e) begin errors++; $display("FAIL seek_data%0d: got %h want %h", i, d, e); end
    end
    repeat (40) @(negedge CLK);
    checks++;
    if (fetch_addr !== 32'h1000 + 32'd8 + 32'd4 || log_q.size() !== 13) begin
      errors++; $display("FAIL seek_fetch_addr: got %h (%0d reqs) want %h (13 reqs)",
                         fetch_addr, log_q.size(), 32'h100C);
    end
    checks++;
    if (log_q.size() == 0 || log_q[0] !== 32'h1000) begin
      errors++; $display("FAIL seek_first_addr: got %h want 00001000", log_q.size() ? log_q[0] : 32'hx);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] d, e;
    logic [31:0] ea [3] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000};
    seek_to(32'hFFFF_FFFE);
    repeat (40) @(negedge CLK);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (log_q.size() <= i || log_q[i] !== ea[i]) begin
        errors++; $display("FAIL wrap_addr%0d: got %h want %h", i, log_q.size() > i ? log_q[i] : 32'hx, ea[i]);
      end
    end
    exp_q.push_back(8'hFE); exp_q.push_back(8'hFF); exp_q.push_back(8'h00);
    for (int i = 0; i < 3; i++) begin
      bus_read(ra(1), d); e = exp_q.pop_front();
      checks++;
      if (d !== e) begin errors++; $display("FAIL wrap_data%0d: got %h want %h", i, d, e); end
    end
    repeat (40) @(negedge CLK);
  endtask

  task automatic test_discard();
    logic [7:0] d, e;
    bus_write(ra(0), 8'h40);
    bus_write(ra(1), 8'h30);
    bus_write(ra(2), 8'h00);
    ack_delay = 10;
    log_q.delete();
    bus_write(ra(3), 8'h00);
    bus_write(ra(3), 8'h01);
    bus_read(ra(1), d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL empty_read: got %h want 00", d); end
    bus_read(ra(0), d);
    checks++;
    if (d[7] !== 1'b1) begin errors++; $display("FAIL empty_busy: got status %h want bit7=1", d); end
    ack_delay = 1;
    repeat (80) @(negedge CLK);
    checks++;
    if (log_q.size() < 3 || log_q[0] !== 32'h0000_3040 || log_q[1] !== 32'h0100_3040 || log_q[2] !== 32'h0100_3041) begin
      errors++; $display("FAIL discard_addrs: got %0d reqs first %h %h want 00003040 01003040",
                         log_q.size(), log_q.size() > 0 ? log_q[0] : 32'hx, log_q.size() > 1 ? log_q[1] : 32'hx);
    end
    exp_q.push_back(8'h40); exp_q.push_back(8'h41); exp_q.push_back(8'h42);
    for (int i = 0; i < 3; i++) begin
      bus_read(ra(1), d); e = exp_q.pop_front();
      checks++;
      if (d !== e) begin errors++; $display("FAIL discard_data%0d: got %h want %h", i, d, e); end
    end
  endtask

  task automatic test_reset_midfetch();
    logic [7:0] d;
    int n;
    repeat (40) @(negedge CLK);
    ack_delay = 10;
    seek_to(32'h0000_5000);
    n = 0;
    while (fetch_req !== 1'b1 && n < 10) begin @(negedge CLK); n++; end
    checks++;
    if (fetch_req !== 1'b1) begin errors++; $display("FAIL midfetch_req: got %b want 1", fetch_req); end
    RST_N = 1'b0;
    #1;
    checks++;
    if (fetch_req !== 1'b0 || DOUT !== 8'h00 || track_out !== 16'h0) begin
      errors++; $display("FAIL midfetch_reset: got freq=%b dout=%h track=%h want 0", fetch_req, DOUT, track_out);
    end
    ack_delay = 1;
    repeat (15) @(negedge CLK);
    log_q.delete();
    RST_N = 1'b1;
    repeat (40) @(negedge CLK);
    checks++;
    if (log_q.size() !== 8 || log_q[0] !== 32'h0) begin
      errors++; $display("FAIL post_reset_fetch: got %0d reqs first %h want 8 reqs first 00000000",
                         log_q.size(), log_q.size() ? log_q[0] : 32'hx);
    end
    exp_q.push_back(8'h00); exp_q.push_back(8'h01);
    for (int i = 0; i < 2; i++) begin
      bus_read(ra(1), d);
      checks++;
      if (d !== exp_q[0]) begin errors++; $display("FAIL post_reset_data%0d: got %h want %h", i, d, exp_q[0]); end
      void'(exp_q.pop_front());
    end
  endtask
`else
  task automatic test_no_data();
    logic [7:0] d;
    int seen;
    seen = 0;
    bus_write(ra(0), 8'h00);
    bus_write(ra(1), 8'h10);
    bus_write(ra(2), 8'h00);
    bus_write(ra(3), 8'h00);
    repeat (20) begin @(negedge CLK); if (fetch_req !== 1'b0) seen++; end
    checks++;
    if (seen !== 0 || fetch_addr !== 32'h0) begin
      errors++; $display("FAIL no_data_fetch: got %0d req cycles addr %h want 0", seen, fetch_addr);
    end
    bus_read(ra(1), d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL no_data_read: got %h want 00", d); end
    bus_read(ra(0), d);
    checks++;
    if (d[7] !== 1'b0) begin errors++; $display("FAIL no_data_busy: got status %h want bit7=0", d); end
  endtask
`endif

  initial begin
    test_reset();
    test_id();
    test_audio_play();
    test_missing();
`ifdef MSU_PORT_DATA_EN
    test_seek();
    test_wrap();
    test_discard();
    test_reset_midfetch();
`else
    test_no_data();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
